// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: the upstream valid/ready pair, the operands,
// and the downstream valid/ready pair with the registered result and flags.
interface alu_seq_if #(
    parameter int unsigned DWIDTH = 8
);
    logic              valid_i;
    logic              ready_o;
    logic [2:0]        sel_i;
    logic [DWIDTH-1:0] op1_i;
    logic [DWIDTH-1:0] op2_i;
    logic              valid_o;
    logic              ready_i;
    logic [DWIDTH-1:0] res_o;
    logic              zero_o;
    logic              neg_o;
    logic              carry_o;
    logic              ovf_o;

    // The ALU itself.
    modport slave (
        input  valid_i, sel_i, op1_i, op2_i, ready_i,
        output ready_o, valid_o, res_o, zero_o, neg_o, carry_o, ovf_o
    );

    // Whoever feeds operands and consumes results.
    modport master (
        output valid_i, sel_i, op1_i, op2_i, ready_i,
        input  ready_o, valid_o, res_o, zero_o, neg_o, carry_o, ovf_o
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/logic ops, iterative one-bit-per-cycle shifts,
// registered result and flags held until the consumer accepts them.
module alu_seq #(
    parameter int unsigned DWIDTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int unsigned SW  = $clog2(DWIDTH);
    localparam int unsigned MSB = DWIDTH - 1;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpSll = 3'b101;
    localparam logic [2:0] OpSrl = 3'b110;
    localparam logic [2:0] OpSra = 3'b111;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic [DWIDTH-1:0] work_q, work_d;
    logic [DWIDTH-1:0] op2_q, op2_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic              shift_op_q, shift_op_d;
    logic [DWIDTH-1:0] res_q, res_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;

    logic [SW-1:0]     shamt_in;
    logic              is_shift_in;
    logic              accept;
    logic [DWIDTH:0]   sum;
    logic [DWIDTH:0]   dif;
    logic [DWIDTH-1:0] alu_res;
    logic              alu_c;
    logic              alu_v;
    logic [DWIDTH-1:0] step;
    logic [DWIDTH-1:0] fin_res;

    assign shamt_in    = bus.op2_i[SW-1:0];
    assign is_shift_in = bus.sel_i[2] & (bus.sel_i[1] | bus.sel_i[0]);
    assign bus.ready_o = (state_q == StIdle) && !reset;
    assign accept      = bus.valid_i && bus.ready_o;

    assign sum = {1'b0, work_q} + {1'b0, op2_q};
    assign dif = {1'b0, work_q} + {1'b0, ~op2_q} + (DWIDTH + 1)'(1);

    // Non-shift ops evaluate on the registered operands; shifts with amount 0 pass op1 through.
    always_comb begin
        alu_res = work_q;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (sel_q)
            OpAdd: begin
                alu_res = sum[DWIDTH-1:0];
                alu_c   = sum[DWIDTH];
                alu_v   = (work_q[MSB] == op2_q[MSB]) && (alu_res[MSB] != work_q[MSB]);
            end
            OpSub: begin
                alu_res = dif[DWIDTH-1:0];
                alu_c   = ~dif[DWIDTH];
                alu_v   = (work_q[MSB] != op2_q[MSB]) && (alu_res[MSB] != work_q[MSB]);
            end
            OpAnd:   alu_res = work_q & op2_q;
            OpOr:    alu_res = work_q | op2_q;
            OpXor:   alu_res = work_q ^ op2_q;
            default: alu_res = work_q;
        endcase
    end

    always_comb begin
        step = work_q;
        case (sel_q)
            OpSll:   step = {work_q[DWIDTH-2:0], 1'b0};
            OpSrl:   step = {1'b0, work_q[DWIDTH-1:1]};
            OpSra:   step = {work_q[MSB], work_q[DWIDTH-1:1]};
            default: step = work_q;
        endcase
    end

    assign fin_res = shift_op_q ? step : alu_res;

    // One-cycle ops also pass through StShift with a count of 1, so the result is produced on
    // the edge after the operands were registered.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        work_d     = work_q;
        op2_d      = op2_q;
        cnt_d      = cnt_q;
        shift_op_d = shift_op_q;
        res_d      = res_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    sel_d      = bus.sel_i;
                    work_d     = bus.op1_i;
                    op2_d      = bus.op2_i;
                    shift_op_d = is_shift_in && (shamt_in != '0);
                    cnt_d      = (is_shift_in && (shamt_in != '0)) ? shamt_in : SW'(1);
                    state_d    = StShift;
                end
            end
            StShift: begin
                work_d = shift_op_q ? step : work_q;
                cnt_d  = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    res_d   = fin_res;
                    zero_d  = (fin_res == '0);
                    neg_d   = fin_res[MSB];
                    carry_d = alu_c;
                    ovf_d   = alu_v;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            work_q     <= '0;
            op2_q      <= '0;
            cnt_q      <= '0;
            shift_op_q <= 1'b0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            work_q     <= work_d;
            op2_q      <= op2_d;
            cnt_q      <= cnt_d;
            shift_op_q <= shift_op_d;
            res_q      <= res_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.valid_o = (state_q == StDone);
    assign bus.res_o   = res_q;
    assign bus.zero_o  = zero_q;
    assign bus.neg_o   = neg_q;
    assign bus.carry_o = carry_q;
    assign bus.ovf_o   = ovf_q;
endmodule
